cordic_seq_ctrl: RTL and testbench
==================================

// Module: cordic_seq_ctrl
// PURPOSE
//   Sequencer for the bit-serial CORDIC datapath (x, y, z shift-register slices, 16-bit).
//   Drives the shared iteration index i, the cross-term bit select, start and the per-slice
//   add/sub controls. Collects xdone/ydone/zdone and runs ITER micro-rotations per request.
//   Sits between the host go/done handshake and the three datapath slices.
// PARAMETERS
//   WIDTH    16  datapath word width; bit-serial cycles per iteration (sel is 4 bits: WIDTH<=16)
//   ITER     16  micro-rotations per operation, 1..31
//   TIMEOUT  20  max RUN cycles waiting for all done flags before abort (>= WIDTH+2)
// PORTS
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   go       in   1  start request, sampled in IDLE only
//   mode     in   1  0 = rotation (steer on z sign), 1 = vectoring (steer on y sign)
//   zsign    in   1  MSB of z register
//   ysign    in   1  MSB of y register
//   xdone    in   1  x slice finished WIDTH shifts
//   ydone    in   1  y slice finished WIDTH shifts
//   zdone    in   1  z slice finished WIDTH shifts
//   i        out  5  iteration index to all slices; 0 = load initial values
//   sel      out  4  cross-term bit select = shift amount of current iteration
//   start    out  1  shift enable to all slices; low clears slice counters/done
//   op_x     out  1  x slice op, 1 = subtract
//   op_y     out  1  y slice op, 1 = subtract
//   op_z     out  1  z slice op, 1 = subtract
//   busy     out  1  high from go acceptance through DONE
//   done     out  1  one-cycle pulse: results valid in slices
//   err      out  1  sticky timeout flag, cleared on next accepted go
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, i=0, sel=0, start=0, op_*=0, busy=0, done=0, err=0.
//   All outputs registered. States: IDLE, LOAD, SETUP, RUN, DONE.
//   IDLE: start=0, i holds (ITER after a run, so slice results hold; 0 after reset).
//     go=1 -> LOAD; err<=0, busy<=1.
//   LOAD (1 cycle): i=0, start=0; slices load x0/y0/z0 and clear carries. -> SETUP, i<=1.
//   SETUP (1 cycle): start=0; sign inputs are now stable for the current i. On exit latch:
//     rotation:  op_y<=zsign, op_x<=~zsign, op_z<=~zsign   (d=+1 when z>=0)
//     vectoring: op_y<=~ysign, op_x<=ysign, op_z<=ysign    (d=+1 when y<0)
//     sel<=min(i-1, WIDTH-1). -> RUN.
//   RUN: start=1; op_*/sel/i frozen for the whole iteration (sign changes ignored).
//     Cycle counter cleared on RUN entry.
//     all_done = xdone&ydone&zdone sampled high -> start<=0;
//       i==ITER -> DONE; else i<=i+1 -> SETUP.
//     counter reaches TIMEOUT without all_done -> err<=1, start<=0, busy<=0 -> IDLE (i holds).
//     Partial done (one or two flags) keeps waiting.
//   DONE (1 cycle): done=1, start=0, i=ITER held; busy<=0 on exit -> IDLE.
//   go outside IDLE ignored; go held high in IDLE relaunches each run.
//   Nominal latency go->done pulse: 2 + ITER*(2+WIDTH) cycles with done flags asserted
//     WIDTH+1 cycles after start rises (=290 cycles for 16/16).
//   Reset mid-operation: immediate abort, start=0, i=0; slices reload on next clock.
// TESTING
//   1 rst_n=0 pulse during RUN of iter 5 -> start=0, i=0, busy=0 same cycle, no done pulse.
//   2 rotation, zsign=0 always, slice model done after 16 start cycles -> i steps 0,1..16;
//     op_x=1 op_y=0 op_z=1; sel=i-1; done pulse 290 cycles after go; busy low after.
//   3 rotation, zsign toggles every SETUP and glitches mid-RUN -> op_y equals zsign at
//     SETUP exit only; no op change while start=1.
//   4 vectoring, ysign=0 -> op_y=1 op_x=0 op_z=0; ysign=1 -> inverted.
//   5 zdone stuck 0 in iter 3 -> err=1 after 20 RUN cycles, start=0, IDLE, i=3;
//     next go clears err and completes normally.
//   6 go pulsed during RUN -> ignored; go held high across done -> LOAD next cycle.

Source files
------------

// File: rtl/cordic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cordic_seq_ctrl
//
// Sequencer for a bit-serial CORDIC datapath made of three shift-register
// slices (x, y, z). For every host request it loads the slices, then runs
// ITER micro-rotations. Each micro-rotation is a SETUP cycle followed by a
// RUN phase in which the slices shift WIDTH bits. During SETUP the direction
// of the rotation is taken from the sign inputs and latched. After the last
// iteration a one-cycle done pulse is given. A RUN phase that never sees all
// three slice done flags is aborted after TIMEOUT cycles. The abort sets a
// sticky err flag.
//
// Parameters
//   WIDTH    datapath word width = shift cycles per iteration (<= 16)
//   ITER     micro-rotations per operation (1..31)
//   TIMEOUT  RUN cycles allowed before abort (>= WIDTH+2)
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   go           in   start request, sampled in IDLE only
//   mode         in   0 = rotation (steer on z sign), 1 = vectoring (steer on y sign)
//   zsign        in   MSB of z register
//   ysign        in   MSB of y register
//   xdone        in   x slice finished WIDTH shifts
//   ydone        in   y slice finished WIDTH shifts
//   zdone        in   z slice finished WIDTH shifts
//   i     [4:0]  out  iteration index to all slices, 0 = load initial values
//   sel   [3:0]  out  cross-term bit select = shift amount of current iteration
//   start        out  shift enable to all slices, low clears slice counters/done
//   op_x         out  x slice op, 1 = subtract
//   op_y         out  y slice op, 1 = subtract
//   op_z         out  z slice op, 1 = subtract
//   busy         out  high from go acceptance through DONE
//   done         out  one-cycle pulse, results valid in slices
//   err          out  sticky timeout flag, cleared by the next accepted go
// ---------------------------------------------------------------------------
module cordic_seq_ctrl #(
    parameter int WIDTH   = 16,
    parameter int ITER    = 16,
    parameter int TIMEOUT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       mode,
    input  logic       zsign,
    input  logic       ysign,
    input  logic       xdone,
    input  logic       ydone,
    input  logic       zdone,
    output logic [4:0] i,
    output logic [3:0] sel,
    output logic       start,
    output logic       op_x,
    output logic       op_y,
    output logic       op_z,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // The RUN counter only has to count up to TIMEOUT-1.
    localparam int                CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [4:0]        ITER_LAST = 5'(ITER);
    localparam logic [4:0]        SHIFT_MAX = 5'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_RUN,
        S_DONE
    } state_t;

    // Shift amount of iteration idx (1-based), saturated at the word width.
    // Beyond WIDTH-1 the cross-term would only ever be sign bits, so the
    // select is clamped at the MSB.
    function automatic logic [3:0] shift_sel(input logic [4:0] idx);
        logic [4:0] w_amt;
        w_amt = idx - 5'd1;
        if (w_amt > SHIFT_MAX) begin
            w_amt = SHIFT_MAX;
        end
        return w_amt[3:0];
    endfunction

    // Rotation direction: 1 means d = +1.
    // Rotation drives z toward zero (d = +1 while z >= 0).
    // Vectoring drives y toward zero (d = +1 while y < 0).
    function automatic logic dir_pos(input logic m, input logic zs, input logic ys);
        return m ? ys : ~zs;
    endfunction

    // Registered state and outputs
    state_t           r_state;
    logic [4:0]       r_i;
    logic [3:0]       r_sel;
    logic             r_start;
    logic             r_op_x;
    logic             r_op_y;
    logic             r_op_z;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    // Next-state values
    state_t           w_state;
    logic [4:0]       w_i;
    logic [3:0]       w_sel;
    logic             w_start;
    logic             w_op_x;
    logic             w_op_y;
    logic             w_op_z;
    logic             w_busy;
    logic             w_done;
    logic             w_err;
    logic [CNT_W-1:0] w_cnt;

    logic             w_all_done;
    logic             w_dir;

    assign w_all_done = xdone & ydone & zdone;
    assign w_dir      = dir_pos(mode, zsign, ysign);

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_sel   <= '0;
            r_start <= 1'b0;
            r_op_x  <= 1'b0;
            r_op_y  <= 1'b0;
            r_op_z  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_i     <= w_i;
            r_sel   <= w_sel;
            r_start <= w_start;
            r_op_x  <= w_op_x;
            r_op_y  <= w_op_y;
            r_op_z  <= w_op_z;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
            r_cnt   <= w_cnt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state = r_state;
        w_i     = r_i;
        w_sel   = r_sel;
        w_start = r_start;
        w_op_x  = r_op_x;
        w_op_y  = r_op_y;
        w_op_z  = r_op_z;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_err   = r_err;
        w_cnt   = r_cnt;

        case (r_state)
            S_IDLE: begin
                // i is left alone so the slices keep presenting their results.
                w_start = 1'b0;
                if (go) begin
                    w_state = S_LOAD;
                    w_i     = '0;
                    w_err   = 1'b0;
                    w_busy  = 1'b1;
                end
            end

            S_LOAD: begin
                // i = 0 during this cycle: the slices load x0/y0/z0.
                w_start = 1'b0;
                w_i     = 5'd1;
                w_state = S_SETUP;
            end

            S_SETUP: begin
                // Signs are settled for the current i. Latch the direction
                // now and hold it for the whole shift phase. The serial
                // update would otherwise see its own partial result.
                w_op_x  = w_dir;
                w_op_y  = ~w_dir;
                w_op_z  = w_dir;
                w_sel   = shift_sel(r_i);
                w_cnt   = '0;
                w_start = 1'b1;
                w_state = S_RUN;
            end

            S_RUN: begin
                if (w_all_done) begin
                    w_start = 1'b0;
                    if (r_i == ITER_LAST) begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_i     = r_i + 5'd1;
                        w_state = S_SETUP;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    // A slice never finished. Abort and leave i at the
                    // failing iteration so it can be inspected.
                    w_start = 1'b0;
                    w_busy  = 1'b0;
                    w_err   = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            S_DONE: begin
                w_start = 1'b0;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end

            default: begin
                w_start = 1'b0;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
        endcase
    end

    assign i     = r_i;
    assign sel   = r_sel;
    assign start = r_start;
    assign op_x  = r_op_x;
    assign op_y  = r_op_y;
    assign op_z  = r_op_z;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cordic_seq_ctrl
//
// Scoreboard bench for the CORDIC sequencer. A behavioural slice model
// raises the done flags after WIDTH enabled shift cycles. For each go, the
// stimulus side pushes the expected outcome onto a queue. The expected
// outcome is either the done cycle or the abort cycle and iteration.
// A monitor on the falling edge pops and compares that entry when done or
// err appears. On every start rise the monitor also checks the iteration
// index, the shift select and the ops against the sign seen at that edge.
// ---------------------------------------------------------------------------
module tb_cordic_seq_ctrl;

    localparam int WIDTH    = 16;
    localparam int ITER     = 16;
    localparam int TIMEOUT  = 20;
    localparam int ITER_CYC = WIDTH + 2;   // SETUP + shift phase per iteration

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       go    = 1'b0;
    logic       mode  = 1'b0;
    logic       zsign = 1'b0;
    logic       ysign = 1'b0;
    logic       xdone;
    logic       ydone;
    logic       zdone;
    logic [4:0] i;
    logic [3:0] sel;
    logic       start;
    logic       op_x;
    logic       op_y;
    logic       op_z;
    logic       busy;
    logic       done;
    logic       err;

    cordic_seq_ctrl #(
        .WIDTH  (WIDTH),
        .ITER   (ITER),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .go   (go),
        .mode (mode),
        .zsign(zsign),
        .ysign(ysign),
        .xdone(xdone),
        .ydone(ydone),
        .zdone(zdone),
        .i    (i),
        .sel  (sel),
        .start(start),
        .op_x (op_x),
        .op_y (op_y),
        .op_z (op_z),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- slice model ----------------
    int         s_cnt    = 0;
    logic       s_flag   = 1'b0;
    logic       stuck_en = 1'b0;
    logic [4:0] stuck_i5 = '0;

    always @(posedge clk) begin
        if (!start) begin
            s_cnt  <= 0;
            s_flag <= 1'b0;
        end else if (s_cnt < WIDTH) begin
            s_cnt  <= s_cnt + 1;
            s_flag <= (s_cnt + 1 >= WIDTH);
        end
    end

    assign xdone = s_flag;
    assign ydone = s_flag;
    assign zdone = s_flag & ~(stuck_en & (i == stuck_i5));

    // ---------------- sign driver: 0 = both low, 1 = both high, 2 = random every cycle
    int pat = 0;

    always begin
        @(posedge clk);
        #1;
        case (pat)
            0: begin
                zsign = 1'b0;
                ysign = 1'b0;
            end
            1: begin
                zsign = 1'b1;
                ysign = 1'b1;
            end
            default: begin
                zsign = 1'($urandom_range(0, 1));
                ysign = 1'($urandom_range(0, 1));
            end
        endcase
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int exp_cyc;
        bit is_err;
        int err_iter;
    } exp_t;

    exp_t sb[$];

    logic [1:0] sign_q;   // {zsign, ysign} as seen by the last rising edge
    logic       mode_q;

    always @(posedge clk) begin
        sign_q <= {zsign, ysign};
        mode_q <= mode;
    end

    logic       p_start = 1'b0;
    logic       p_busy  = 1'b0;
    logic       p_err   = 1'b0;
    logic [2:0] p_ops   = '0;
    logic [3:0] p_sel   = '0;
    logic [4:0] p_i     = '0;

    int   it_k      = 0;
    bit   busy_chk  = 0;
    int   done_seen = 0;
    exp_t e_mon;
    logic d_mon;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            p_start  = 1'b0;
            p_busy   = 1'b0;
            p_err    = 1'b0;
            it_k     = 0;
            busy_chk = 0;
        end else begin
            if (busy_chk) begin
                chk("busy_low_after_done", busy, 0);
                busy_chk = 0;
            end

            if (busy && !p_busy) begin
                it_k = 0;
                chk("err_cleared_on_go", err, 0);
            end

            if (start && !p_start) begin
                it_k++;
                d_mon = mode_q ? sign_q[0] : ~sign_q[1];
                chk("iter_index", i, it_k);
                chk("sel", sel, (it_k - 1 < WIDTH) ? it_k - 1 : WIDTH - 1);
                chk("op_x", op_x, d_mon);
                chk("op_y", op_y, !d_mon);
                chk("op_z", op_z, d_mon);
            end else if (start && p_start) begin
                chk("frozen_during_run", {op_x, op_y, op_z, sel, i}, {p_ops, p_sel, p_i});
            end

            if (done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    e_mon = sb.pop_front();
                    chk("done_expected_not_err", e_mon.is_err, 0);
                    chk("done_cycle", cyc, e_mon.exp_cyc);
                    chk("done_i", i, ITER);
                    chk("done_busy", busy, 1);
                    chk("done_start", start, 0);
                    busy_chk = 1;
                end
            end

            if (err && !p_err) begin
                if (sb.size() == 0) begin
                    fail("unexpected_err");
                end else begin
                    e_mon = sb.pop_front();
                    chk("err_expected", e_mon.is_err, 1);
                    chk("err_cycle", cyc, e_mon.exp_cyc);
                    chk("err_i", i, e_mon.err_iter);
                    chk("err_start", start, 0);
                    chk("err_busy", busy, 0);
                end
            end

            p_start = start;
            p_busy  = busy;
            p_err   = err;
            p_ops   = {op_x, op_y, op_z};
            p_sel   = sel;
            p_i     = i;
        end
    end

    // ---------------- stimulus ----------------
    // Issue one go pulse and record the expected outcome. With twice set,
    // go stays high across done so a second run starts from IDLE.
    task automatic launch(input logic m, input int p, input bit stk, input int stk_it,
                          input bit twice);
        exp_t e;
        exp_t e2;
        int   acc;
        int   acc2;
        @(posedge clk);
        #1;
        mode     = m;
        pat      = p;
        stuck_en = stk;
        stuck_i5 = 5'(stk_it);
        go       = 1'b1;
        acc      = cyc + 1;
        e.is_err   = stk;
        e.err_iter = stk_it;
        e.exp_cyc  = stk ? acc + 2 + (stk_it - 1) * ITER_CYC + TIMEOUT
                         : acc + 1 + ITER * ITER_CYC;
        sb.push_back(e);
        if (twice) begin
            // DONE occupies one cycle, IDLE the next, where go is taken again.
            acc2        = e.exp_cyc + 2;
            e2.is_err   = 0;
            e2.err_iter = 0;
            e2.exp_cyc  = acc2 + 1 + ITER * ITER_CYC;
            sb.push_back(e2);
            repeat (acc2 - cyc) @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
        end
        go = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail({"wait_idle_timeout_", tag});
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        int ds;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_i", i, 0);
        chk("rst_sel", sel, 0);
        chk("rst_start", start, 0);
        chk("rst_ops", {op_x, op_y, op_z}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Rotation with z never negative, then z always negative, then random signs
        launch(1'b0, 0, 0, 0, 0);
        wait_idle("rot0");
        chk("i_hold_after_done", i, ITER);
        chk("busy_idle", busy, 0);
        launch(1'b0, 1, 0, 0, 0);
        wait_idle("rot1");
        launch(1'b0, 2, 0, 0, 0);
        wait_idle("rot_rand");

        // Vectoring with y positive, y negative and random
        launch(1'b1, 0, 0, 0, 0);
        wait_idle("vec0");
        launch(1'b1, 1, 0, 0, 0);
        wait_idle("vec1");
        launch(1'b1, 2, 0, 0, 0);
        wait_idle("vec_rand");

        // zdone stuck in iteration 3, then a clean run
        launch(1'b0, 2, 1, 3, 0);
        wait_idle("stuck");
        stuck_en = 1'b0;
        chk("i_hold_after_abort", i, 3);
        chk("err_sticky", err, 1);
        chk("start_after_abort", start, 0);
        repeat (5) @(negedge clk);
        chk("err_still_sticky", err, 1);
        launch(1'b0, 2, 0, 0, 0);
        wait_idle("after_abort");
        chk("err_after_clean_run", err, 0);

        // go pulse during a shift phase is ignored
        launch(1'b1, 2, 0, 0, 0);
        n = 0;
        while (!(start && i == 5'd2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail("wait_iter2");
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        wait_idle("go_in_run");

        // go held high across done relaunches
        launch(1'b0, 2, 0, 0, 1);
        wait_idle("held_go");

        // Reset during the shift phase of iteration 5
        launch(1'b0, 2, 0, 0, 0);
        n = 0;
        while (!(start && i == 5'd5) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail("wait_iter5");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_start", start, 0);
        chk("midrun_rst_i", i, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        ds = done_seen;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done_after_rst", done_seen - ds, 0);
        chk("idle_after_rst_i", i, 0);
        chk("idle_after_rst_busy", busy, 0);

        // A clean run after the reset
        launch(1'b1, 2, 0, 0, 0);
        wait_idle("post_rst");
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
